// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Holds the instruction fetch PC. It selects the next PC from the exception,
// eret, branch, return-address-stack, stall and sequential sources. A small
// BOOT/RUN/HANDLER state machine tracks start-up and exception handling.
//
// Optional feature macro: PC_RAS_EN
//   defined   -> a circular return-address stack is built. Calls push pc+INC
//                and returns pop to the stack top.
//   undefined -> no RAS storage. push_ras/pop_ras have no effect, and the
//                outputs read ras_top=0, ras_empty=1, ras_full=0.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   stall_f       in   hold the PC (a redirect still takes effect)
//   flush_branch  in   taken branch/jump to branch_target
//   branch_target in   redirect address
//   push_ras      in   call marker, honoured only when the branch wins
//   pop_ras       in   return, redirect to the RAS top
//   exc_req       in   exception request (honoured in RUN only)
//   eret_req      in   return from exception (honoured in HANDLER only)
//   pc            out  current fetch PC (registered)
//   pc_valid      out  pc is a valid fetch address (RUN/HANDLER)
//   epc           out  saved exception PC
//   in_handler    out  FSM is in HANDLER
//   ras_top       out  most recent un-popped RAS entry, 0 when empty
//   ras_empty     out  RAS holds no entries
//   ras_full      out  RAS holds RAS_DEPTH entries
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter int unsigned       WIDTH      = 32,
  parameter logic [WIDTH-1:0]  RESET_PC   = 32'h0000_1000,
  parameter logic [WIDTH-1:0]  EXC_VECTOR = 32'h0000_2000,
  parameter int unsigned       INC        = 4,
  parameter int unsigned       RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             flush_branch,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             push_ras,
  input  logic             pop_ras,
  input  logic             exc_req,
  input  logic             eret_req,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] epc,
  output logic             in_handler,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full
);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'b00,
    ST_RUN     = 2'b01,
    ST_HANDLER = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_nxt_s;
  logic [WIDTH-1:0] epc_r;
  logic [WIDTH-1:0] epc_nxt_s;
  logic             pc_valid_r;
  logic             in_handler_r;
  logic [WIDTH-1:0] pc_inc_s;

  // Winning-source qualifiers fed to the RAS.
  logic             ras_push_s;
  logic             ras_pop_s;

  // RAS status as seen by the next-PC selection.
  logic [WIDTH-1:0] ras_top_s;
  logic             ras_empty_s;

  // Sequential increment wraps naturally at the WIDTH-bit boundary.
  assign pc_inc_s = pc_r + WIDTH'(INC);

  // Next-state, next-PC and next-EPC selection in priority order.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    epc_nxt_s   = epc_r;
    ras_push_s  = 1'b0;
    ras_pop_s   = 1'b0;
    case (state_r)
      ST_BOOT: begin
        // Every request input is ignored while booting.
        state_nxt_s = ST_RUN;
        pc_nxt_s    = RESET_PC;
      end
      ST_RUN, ST_HANDLER: begin
        if ((state_r == ST_RUN) && exc_req) begin
          epc_nxt_s   = pc_r;
          pc_nxt_s    = EXC_VECTOR;
          state_nxt_s = ST_HANDLER;
        end else if ((state_r == ST_HANDLER) && eret_req) begin
          pc_nxt_s    = epc_r;
          state_nxt_s = ST_RUN;
        end else if (flush_branch) begin
          // The branch outranks any concurrent pop, so only the push can land.
          pc_nxt_s   = branch_target;
          ras_push_s = push_ras;
        end else if (pop_ras && !ras_empty_s) begin
          pc_nxt_s  = ras_top_s;
          ras_pop_s = 1'b1;
        end else if (stall_f) begin
          pc_nxt_s = pc_r;
        end else begin
          pc_nxt_s = pc_inc_s;
        end
      end
      default: begin
        state_nxt_s = ST_BOOT;
        pc_nxt_s    = RESET_PC;
      end
    endcase
  end

  // State, PC, EPC and the status outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_BOOT;
      pc_r         <= RESET_PC;
      epc_r        <= {WIDTH{1'b0}};
      pc_valid_r   <= 1'b0;
      in_handler_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      epc_r        <= epc_nxt_s;
      pc_valid_r   <= (state_nxt_s != ST_BOOT);
      in_handler_r <= (state_nxt_s == ST_HANDLER);
    end
  end

  assign pc         = pc_r;
  assign epc        = epc_r;
  assign pc_valid   = pc_valid_r;
  assign in_handler = in_handler_r;

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  // Circular buffer. ras_ptr_r indexes the newest entry. When the buffer is
  // full, a push lands on the oldest slot and overwrites it.
  logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_r;
  logic [PTR_W-1:0] ras_ptr_nxt_s;
  logic [PTR_W-1:0] ras_wr_idx_s;
  logic [CNT_W-1:0] ras_cnt_r;
  logic [CNT_W-1:0] ras_cnt_nxt_s;
  logic [WIDTH-1:0] ras_top_r;
  logic [WIDTH-1:0] ras_top_nxt_s;
  logic             ras_empty_r;
  logic             ras_full_r;

  assign ras_wr_idx_s = ras_ptr_r + PTR_W'(1);

  // Pointer/count update. A power-of-two depth lets the pointer wrap for free.
  always_comb begin
    ras_ptr_nxt_s = ras_ptr_r;
    ras_cnt_nxt_s = ras_cnt_r;
    if (ras_push_s) begin
      ras_ptr_nxt_s = ras_wr_idx_s;
      if (ras_cnt_r != CNT_W'(RAS_DEPTH)) begin
        ras_cnt_nxt_s = ras_cnt_r + CNT_W'(1);
      end else begin
        ras_cnt_nxt_s = ras_cnt_r;
      end
    end else if (ras_pop_s) begin
      ras_ptr_nxt_s = ras_ptr_r - PTR_W'(1);
      ras_cnt_nxt_s = ras_cnt_r - CNT_W'(1);
    end else begin
      ras_ptr_nxt_s = ras_ptr_r;
      ras_cnt_nxt_s = ras_cnt_r;
    end
  end

  // Next visible top entry. A pushed value bypasses the storage write.
  always_comb begin
    ras_top_nxt_s = {WIDTH{1'b0}};
    if (ras_push_s) begin
      ras_top_nxt_s = pc_inc_s;
    end else if (ras_cnt_nxt_s == {CNT_W{1'b0}}) begin
      ras_top_nxt_s = {WIDTH{1'b0}};
    end else begin
      ras_top_nxt_s = ras_mem_r[ras_ptr_nxt_s];
    end
  end

  // RAS storage and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_mem_r[i] <= {WIDTH{1'b0}};
      end
      ras_ptr_r   <= {PTR_W{1'b0}};
      ras_cnt_r   <= {CNT_W{1'b0}};
      ras_top_r   <= {WIDTH{1'b0}};
      ras_empty_r <= 1'b1;
      ras_full_r  <= 1'b0;
    end else begin
      if (ras_push_s) begin
        ras_mem_r[ras_wr_idx_s] <= pc_inc_s;
      end
      ras_ptr_r   <= ras_ptr_nxt_s;
      ras_cnt_r   <= ras_cnt_nxt_s;
      ras_top_r   <= ras_top_nxt_s;
      ras_empty_r <= (ras_cnt_nxt_s == {CNT_W{1'b0}});
      ras_full_r  <= (ras_cnt_nxt_s == CNT_W'(RAS_DEPTH));
    end
  end

  assign ras_top_s   = ras_top_r;
  assign ras_empty_s = ras_empty_r;
  assign ras_top     = ras_top_r;
  assign ras_empty   = ras_empty_r;
  assign ras_full    = ras_full_r;
`else
  // No stack is built. It always reads as empty, so a pop can never win.
  logic ras_unused_s;

  assign ras_unused_s = ras_push_s ^ ras_pop_s;
  assign ras_top_s    = {WIDTH{1'b0}};
  assign ras_empty_s  = 1'b1;
  assign ras_top      = {WIDTH{1'b0}};
  assign ras_empty    = 1'b1;
  assign ras_full     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] EXC_PC = 32'h0000_2000;
  localparam int          DEPTH  = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stall_f;
  logic        flush_branch;
  logic [31:0] branch_target;
  logic        push_ras;
  logic        pop_ras;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] epc;
  logic        in_handler;
  logic [31:0] ras_top;
  logic        ras_empty;
  logic        ras_full;

  fetch_pc_unit dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .flush_branch(flush_branch),
    .branch_target(branch_target), .push_ras(push_ras), .pop_ras(pop_ras),
    .exc_req(exc_req), .eret_req(eret_req), .pc(pc), .pc_valid(pc_valid),
    .epc(epc), .in_handler(in_handler), .ras_top(ras_top),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] ras_top;
    logic        pc_valid;
    logic        in_handler;
    logic        ras_empty;
    logic        ras_full;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;

  // Reference model: architectural view with the RAS as a plain queue.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  bit          m_boot;
  bit          m_hand;
  logic [31:0] m_ras[$];

  logic [31:0] pop_exp [5] = '{32'h1014, 32'h1010, 32'h100C, 32'h1008, 32'h100C};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc   = RST_PC;
    m_epc  = 32'h0;
    m_boot = 1'b1;
    m_hand = 1'b0;
    m_ras.delete();
  endfunction

  function automatic void model_step(input logic s, input logic b, input logic [31:0] t,
                                     input logic pu, input logic po, input logic e, input logic er);
    if (m_boot) begin
      m_boot = 1'b0;
      return;
    end
    if (e && !m_hand) begin
      m_epc  = m_pc;
      m_pc   = EXC_PC;
      m_hand = 1'b1;
    end else if (er && m_hand) begin
      m_pc   = m_epc;
      m_hand = 1'b0;
    end else if (b) begin
      if (RAS_EN && pu) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      m_pc = t;
    end else if (RAS_EN && po && m_ras.size() > 0) begin
      m_pc = m_ras.pop_back();
    end else if (!s) begin
      m_pc = m_pc + 32'd4;
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.pc         = m_pc;
    e.epc        = m_epc;
    e.pc_valid   = !m_boot;
    e.in_handler = m_hand;
    if (RAS_EN) begin
      e.ras_top   = (m_ras.size() > 0) ? m_ras[$] : 32'h0;
      e.ras_empty = (m_ras.size() == 0);
      e.ras_full  = (m_ras.size() == DEPTH);
    end else begin
      e.ras_top   = 32'h0;
      e.ras_empty = 1'b1;
      e.ras_full  = 1'b0;
    end
    exp_q.push_back(e);
  endfunction

  // One clock of stimulus: drive on the falling edge, predict the next edge.
  task automatic step(input logic s, input logic b, input logic [31:0] t,
                      input logic pu, input logic po, input logic e, input logic er);
    @(negedge clk);
    rst = 1'b0; stall_f = s; flush_branch = b; branch_target = t;
    push_ras = pu; pop_ras = po; exc_req = e; eret_req = er;
    if (m_boot) begin
      #1;
      chk("boot_pc_valid", {31'h0, pc_valid}, 32'h0);
      chk("boot_pc", pc, RST_PC);
    end
    model_step(s, b, t, pu, po, e, er);
    push_exp();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    stall_f = 1'($urandom); flush_branch = 1'($urandom); branch_target = $urandom;
    push_ras = 1'($urandom); pop_ras = 1'($urandom); exc_req = 1'($urandom);
    eret_req = 1'($urandom);
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_pc_valid", {31'h0, pc_valid}, 32'h0);
    chk("rst_in_handler", {31'h0, in_handler}, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_ras_empty", {31'h0, ras_empty}, 32'h1);
    chk("rst_ras_full", {31'h0, ras_full}, 32'h0);
    chk("rst_ras_top", ras_top, 32'h0);
    model_reset();
  endtask

  task automatic expect_pc(input string name, input logic [31:0] v);
    @(posedge clk);
    #2;
    chk(name, pc, v);
  endtask

  // Monitor: compares DUT outputs after every edge that has a prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("pc", pc, mon_e.pc);
        chk("epc", epc, mon_e.epc);
        chk("pc_valid", {31'h0, pc_valid}, {31'h0, mon_e.pc_valid});
        chk("in_handler", {31'h0, in_handler}, {31'h0, mon_e.in_handler});
        chk("ras_top", ras_top, mon_e.ras_top);
        chk("ras_empty", {31'h0, ras_empty}, {31'h0, mon_e.ras_empty});
        chk("ras_full", {31'h0, ras_full}, {31'h0, mon_e.ras_full});
      end
    end
  end

  initial begin
    rst = 1'b1; stall_f = 1'b0; flush_branch = 1'b0; branch_target = 32'h0;
    push_ras = 1'b0; pop_ras = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
    model_reset();

    // Release from reset with idle inputs.
    do_reset();
    idle(); expect_pc("r037_0", 32'h1000);
    idle(); expect_pc("r037_1", 32'h1004);
    idle(); expect_pc("r037_2", 32'h1008);

    // A redirect beats a stall, and a stall alone holds.
    step(1'b1, 1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0); expect_pc("r038_br", 32'h3000);
    step(1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0); expect_pc("r038_hold", 32'h3000);

    // Exception entry, ignored nested exception, then eret.
    step(1'b0, 1'b1, 32'h1010, 1'b0, 1'b0, 1'b0, 1'b0); expect_pc("r039_pre", 32'h1010);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0); expect_pc("r039_exc", 32'h2000);
    chk("r039_epc", epc, 32'h1010);
    chk("r039_inh", {31'h0, in_handler}, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0); expect_pc("r039_nest", 32'h2004);
    chk("r039_epc2", epc, 32'h1010);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); expect_pc("r039_eret", 32'h1010);
    chk("r039_inh0", {31'h0, in_handler}, 32'h0);

    // Wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0); expect_pc("r042_pre", 32'hFFFF_FFFC);
    idle(); expect_pc("r042_wrap", 32'h0);

    // Five calls overflow a 4-deep stack, then pop back down past empty.
    step(1'b0, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 32'h1004 + 32'(4 * k), 1'b1, 1'b0, 1'b0, 1'b0);
    end
`ifdef PC_RAS_EN
    expect_pc("r040_callpc", 32'h1014);
    chk("r040_full", {31'h0, ras_full}, 32'h1);
    chk("r040_top", ras_top, 32'h1014);
`endif
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef PC_RAS_EN
      expect_pc("r040_pop", pop_exp[k]);
`endif
    end

    // Branch, push and pop in one cycle: the branch and push win.
    step(1'b0, 1'b1, 32'h5000, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef PC_RAS_EN
    expect_pc("r041_pc", 32'h5000);
    chk("r041_top", ras_top, 32'h1010);
    chk("r041_nempty", {31'h0, ras_empty}, 32'h0);
`endif

    // Reset while in the handler.
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        logic [31:0] t;
        case ($urandom_range(0, 3))
          0:       t = 32'hFFFF_FFF0 + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
          1:       t = 32'h0000_1000 + {20'h0, 10'($urandom), 2'b00};
          default: t = $urandom;
        endcase
        step(($urandom_range(0, 3) == 0),
             ($urandom_range(0, 6) == 0),
             t,
             ($urandom_range(0, 1) == 0),
             ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 7) == 0));
      end
    end

    // Drain outstanding predictions within a bounded number of cycles.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter WIDTH, 32, PC/address width in bits.
REQ-002 Parameter RESET_PC, 32'h0000_1000, PC loaded on reset.
REQ-003 Parameter EXC_VECTOR, 32'h0000_2000, exception handler entry address.
REQ-004 Parameter INC, 4, sequential PC increment.
REQ-005 Parameter RAS_DEPTH, 4, return-address-stack entries (power of two, 2..16).
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 stall_f  in  1  hold PC (fetch stall).
REQ-009 flush_branch  in  1  taken branch/jump; redirect to branch_target.
REQ-010 branch_target  in  WIDTH  redirect address.
REQ-011 push_ras  in  1  call marker; valid only with flush_branch.
REQ-012 pop_ras  in  1  return; redirect to RAS top.
REQ-013 exc_req  in  1  exception request.
REQ-014 eret_req  in  1  return from exception.
REQ-015 pc  out  WIDTH  current fetch PC (registered).
REQ-016 pc_valid  out  1  pc is a valid fetch address.
REQ-017 epc  out  WIDTH  saved exception PC.
REQ-018 in_handler  out  1  FSM in HANDLER state.
REQ-019 ras_top / ras_empty / ras_full  out  WIDTH/1/1  RAS top entry and status.

Function
REQ-020 FSM states BOOT, RUN, HANDLER; BOOT->RUN unconditionally after one cycle; RUN->HANDLER on exc_req; HANDLER->RUN on eret_req.
REQ-021 pc_valid SHALL be 0 in BOOT, 1 in RUN and HANDLER; in_handler SHALL be 1 only in HANDLER.
REQ-022 In BOOT pc SHALL hold RESET_PC regardless of inputs; all request inputs ignored.
REQ-023 Next-PC priority, highest first: exc_req (RUN only), eret_req (HANDLER only), flush_branch, effective pop, stall_f hold, pc+INC.
REQ-024 Redirects (exception, eret, branch, pop) SHALL take effect on the next edge even when stall_f=1.
REQ-025 Exception: epc <= pc, pc <= EXC_VECTOR; exc_req in HANDLER SHALL be ignored (no nesting, epc unchanged).
REQ-026 Eret: pc <= epc; eret_req in RUN SHALL be ignored.
REQ-027 pc+INC SHALL wrap modulo 2^WIDTH.
REQ-028 Push effective only when flush_branch is the winning source: push pc+INC onto RAS.
REQ-029 Pop effective only when it is the winning source and RAS non-empty: pc <= ras_top, entry removed; pop on empty SHALL fall through to stall/sequential.
REQ-030 Push when full SHALL overwrite the oldest entry (circular); count saturates at RAS_DEPTH, ras_full stays 1.
REQ-031 Push and pop together never both effective (branch outranks pop); pop SHALL be ignored.
REQ-032 ras_top SHALL equal most recent un-popped entry; 0 when empty.
REQ-033 RAS and epc SHALL be unaffected by stall_f.

Reset
REQ-034 Asserting rst at any time SHALL immediately force pc=RESET_PC, state=BOOT, pc_valid=0, in_handler=0, epc=0, RAS empty (ras_empty=1, ras_full=0, ras_top=0).
REQ-035 Deassertion SHALL be followed by exactly one BOOT cycle before RUN.

Configuration
REQ-036 Macro PC_RAS_EN: defined -> RAS as REQ-028..032; undefined -> no RAS storage, push_ras/pop_ras ignored, ras_top=0, ras_empty=1, ras_full=0.

Verification
REQ-037 Release rst, idle inputs -> pc 0x1000 pc_valid=0 one cycle, then 0x1000, 0x1004, 0x1008 with pc_valid=1.
REQ-038 pc=0x1008, stall_f=1 + flush_branch target 0x3000 -> next pc 0x3000; stall_f alone next cycle -> pc holds 0x3000.
REQ-039 pc=0x1010, exc_req -> pc 0x2000, epc 0x1010, in_handler=1; second exc_req -> ignored; eret_req -> pc 0x1010, in_handler=0.
REQ-040 (PC_RAS_EN) 5 calls at pc 0x1000..0x1010 step 4 with push -> ras_full=1, 5 pops return 0x1014,0x1010,0x100C,0x1008 then empty pop gives sequential pc+4.
REQ-041 flush_branch+push_ras+pop_ras same cycle -> branch taken, entry pushed, nothing popped.
REQ-042 pc=WIDTH'hFFFF_FFFC sequential -> 0x0000_0000; rst mid-HANDLER -> immediate pc 0x1000, in_handler=0.
